// File: rtl/vga_scan_timing.sv
// VGA raster timing generator: pixel/line counters with registered enables, syncs and frame pulses.
// Optional macro VGA_SCAN_SYNC_DELAY_EN adds one register stage on hs/vs to match a registered pixel path.
module vga_scan_timing #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 56,
    parameter int   H_SYNC   = 120,
    parameter int   H_BP     = 64,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 37,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 23,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        pclk,
    input  logic        rst,
    output logic        hen,
    output logic        ven,
    output logic        hs,
    output logic        vs,
    output logic [10:0] hcnt,
    output logic [9:0]  vcnt,
    output logic        frame_start,
    output logic        line_start,
    output logic [7:0]  frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS_END  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        hen_q, hen_d;
    logic        ven_q, ven_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        frame_start_q, frame_start_d;
    logic        line_start_q, line_start_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        h_wrap;
    logic        v_wrap;

    // Wrap on >= so the counters cannot escape their range even from a corrupted value.
    always_comb begin
        h_wrap = (hcnt_q >= H_LAST);
        v_wrap = (vcnt_q >= V_LAST);

        hcnt_d = h_wrap ? 11'd0 : hcnt_q + 11'd1;
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            vcnt_d = v_wrap ? 10'd0 : vcnt_q + 10'd1;
        end
    end

    // All outputs decode the next counter values so they line up with hcnt/vcnt in the same cycle.
    always_comb begin
        hen_d         = (hcnt_d < H_VIS_END);
        ven_d         = (vcnt_d < V_VIS_END);
        hs_d          = ((hcnt_d >= H_SYNC_BEG) && (hcnt_d < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        vs_d          = ((vcnt_d >= V_SYNC_BEG) && (vcnt_d < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        line_start_d  = (hcnt_d == 11'd0);
        frame_start_d = (hcnt_d == 11'd0) && (vcnt_d == 10'd0);
        frame_cnt_d   = frame_start_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    // Reset parks the raster on its last position so the first free edge lands on (0,0).
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcnt_q        <= H_LAST;
            vcnt_q        <= V_LAST;
            hen_q         <= 1'b0;
            ven_q         <= 1'b0;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            frame_cnt_q   <= 8'hFF;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hen_q         <= hen_d;
            ven_q         <= ven_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

`ifdef VGA_SCAN_SYNC_DELAY_EN
    logic hs_dly_q, hs_dly_d;
    logic vs_dly_q, vs_dly_d;

    always_comb begin
        hs_dly_d = hs_q;
        vs_dly_d = vs_q;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hs_dly_q <= ~SYNC_POL;
            vs_dly_q <= ~SYNC_POL;
        end else begin
            hs_dly_q <= hs_dly_d;
            vs_dly_q <= vs_dly_d;
        end
    end

    assign hs = hs_dly_q;
    assign vs = vs_dly_q;
`else
    assign hs = hs_q;
    assign vs = vs_q;
`endif

    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign hen         = hen_q;
    assign ven         = ven_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_scan_timing.sv
// Directed bench for vga_scan_timing: one default-timing instance for line checks and
// one shrunken-raster instance (16x8) so whole frames and the frame counter wrap stay short.
module tb_vga_scan_timing;

    localparam int DLY =
`ifdef VGA_SCAN_SYNC_DELAY_EN
        1;
`else
        0;
`endif

    logic pclk;
    logic rst;

    logic        d_hen, d_ven, d_hs, d_vs, d_fs, d_ls;
    logic [10:0] d_hcnt;
    logic [9:0]  d_vcnt;
    logic [7:0]  d_fc;

    logic        s_hen, s_ven, s_hs, s_vs, s_fs, s_ls;
    logic [10:0] s_hcnt;
    logic [9:0]  s_vcnt;
    logic [7:0]  s_fc;

    int checks;
    int failures;

    vga_scan_timing u_dflt (
        .pclk(pclk), .rst(rst), .hen(d_hen), .ven(d_ven), .hs(d_hs), .vs(d_vs),
        .hcnt(d_hcnt), .vcnt(d_vcnt), .frame_start(d_fs), .line_start(d_ls), .frame_cnt(d_fc)
    );

    // Small raster: H 8+2+3+3=16 (hs at 10..12), V 4+1+2+1=8 (vs at lines 5..6), 128 cycles/frame.
    vga_scan_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) u_small (
        .pclk(pclk), .rst(rst), .hen(s_hen), .ven(s_ven), .hs(s_hs), .vs(s_vs),
        .hcnt(s_hcnt), .vcnt(s_vcnt), .frame_start(s_fs), .line_start(s_ls), .frame_cnt(s_fc)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(5);
        checks++;
        if (d_hcnt !== 11'd1039 || d_vcnt !== 10'd665 || d_fc !== 8'hFF) begin
            failures++;
            $display("FAIL reset_dflt_cnt: got h=%0d v=%0d fc=%0d expected h=1039 v=665 fc=255", d_hcnt, d_vcnt, d_fc);
        end
        checks++;
        if ({d_hen, d_ven, d_hs, d_vs, d_fs, d_ls} !== 6'b000000) begin
            failures++;
            $display("FAIL reset_dflt_flags: got %b expected 000000", {d_hen, d_ven, d_hs, d_vs, d_fs, d_ls});
        end
        checks++;
        if (s_hcnt !== 11'd15 || s_vcnt !== 10'd7 || s_fc !== 8'hFF ||
            {s_hen, s_ven, s_hs, s_vs, s_fs, s_ls} !== 6'b000000) begin
            failures++;
            $display("FAIL reset_small: got h=%0d v=%0d fc=%0d flags=%b expected h=15 v=7 fc=255 flags=000000",
                     s_hcnt, s_vcnt, s_fc, {s_hen, s_ven, s_hs, s_vs, s_fs, s_ls});
        end
        rst = 1'b0;
        tick(1);
        checks++;
        if (d_hcnt !== 11'd0 || d_vcnt !== 10'd0 || d_fc !== 8'd0) begin
            failures++;
            $display("FAIL release_dflt_cnt: got h=%0d v=%0d fc=%0d expected h=0 v=0 fc=0", d_hcnt, d_vcnt, d_fc);
        end
        checks++;
        if ({d_hen, d_ven, d_fs, d_ls, d_hs, d_vs} !== 6'b111100) begin
            failures++;
            $display("FAIL release_dflt_flags: got hen,ven,fs,ls,hs,vs=%b expected 111100",
                     {d_hen, d_ven, d_fs, d_ls, d_hs, d_vs});
        end
    endtask

    // Walks one default line starting from (0,0) right after reset release.
    task automatic test_line_default();
        int bad_h = 0, hen_n = 0, hs_n = 0, ls_n = 0, hs_first = -1, hs_last = -1, hen_last = -1;
        for (int i = 0; i < 1040; i++) begin
            if (d_hcnt !== 11'(i) || d_vcnt !== 10'd0) bad_h++;
            if (d_hen === 1'b1) begin hen_n++; hen_last = i; end
            if (d_hs === 1'b1) begin
                hs_n++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
            if (d_ls === 1'b1) ls_n++;
            tick(1);
        end
        checks++;
        if (bad_h !== 0) begin
            failures++;
            $display("FAIL line_hcnt_seq: got %0d bad cycles expected 0", bad_h);
        end
        checks++;
        if (hen_n !== 800 || hen_last !== 799) begin
            failures++;
            $display("FAIL line_hen: got count=%0d last=%0d expected count=800 last=799", hen_n, hen_last);
        end
        checks++;
        if (hs_n !== 120 || hs_first !== 856 + DLY || hs_last !== 975 + DLY) begin
            failures++;
            $display("FAIL line_hs: got count=%0d first=%0d last=%0d expected 120 %0d %0d",
                     hs_n, hs_first, hs_last, 856 + DLY, 975 + DLY);
        end
        checks++;
        if (ls_n !== 1 || d_ls !== 1'b1 || d_hcnt !== 11'd0 || d_vcnt !== 10'd1 || d_fs !== 1'b0) begin
            failures++;
            $display("FAIL line_period: got ls_n=%0d ls=%b h=%0d v=%0d fs=%b expected 1 1 0 1 0",
                     ls_n, d_ls, d_hcnt, d_vcnt, d_fs);
        end
    endtask

    // Two full small frames against an independent positional model.
    task automatic test_frames_small();
        int bad = 0, fs_n = 0, fs_second = -1, vs_n = 0, vs_first = -1, vis = 0;
        int eh, ev;
        logic hs_now, vs_now, e_hs, e_vs, hs_prev, vs_prev;
        hs_prev = 1'b0;
        vs_prev = 1'b0;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            eh = i % 16;
            ev = (i / 16) % 8;
            hs_now = (eh >= 10 && eh < 13);
            vs_now = (ev >= 5 && ev < 7);
            e_hs = (DLY == 1) ? hs_prev : hs_now;
            e_vs = (DLY == 1) ? vs_prev : vs_now;
            if (s_hcnt !== 11'(eh) || s_vcnt !== 10'(ev) || s_hen !== (eh < 8) || s_ven !== (ev < 4) ||
                s_hs !== e_hs || s_vs !== e_vs || s_ls !== (eh == 0) ||
                s_fs !== (eh == 0 && ev == 0) || s_fc !== 8'(i / 128)) bad++;
            if (s_fs === 1'b1) begin
                fs_n++;
                if (i > 0) fs_second = i;
            end
            if (s_vs === 1'b1) begin
                vs_n++;
                if (vs_first < 0) vs_first = i;
            end
            if (s_hen === 1'b1 && s_ven === 1'b1) vis++;
            hs_prev = hs_now;
            vs_prev = vs_now;
            tick(1);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL frame_model: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (fs_n !== 2 || fs_second !== 128) begin
            failures++;
            $display("FAIL frame_period: got count=%0d second=%0d expected 2 128", fs_n, fs_second);
        end
        checks++;
        if (vs_n !== 64 || vs_first !== 80 + DLY) begin
            failures++;
            $display("FAIL frame_vs: got count=%0d first=%0d expected 64 %0d", vs_n, vs_first, 80 + DLY);
        end
        checks++;
        if (vis !== 64) begin
            failures++;
            $display("FAIL frame_visible: got %0d expected 64", vis);
        end
    endtask

    // Reset asserted at small (11,5), inside both hs and vs.
    task automatic test_reset_mid();
        do_reset();
        tick(91);
        checks++;
        if (s_hcnt !== 11'd11 || s_vcnt !== 10'd5 || s_hs !== 1'b1 || s_vs !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: got h=%0d v=%0d hs=%b vs=%b expected 11 5 1 1", s_hcnt, s_vcnt, s_hs, s_vs);
        end
        rst = 1'b1;
        tick(1);
        checks++;
        if ({s_hs, s_vs, s_hen, s_ven, s_fs, s_ls} !== 6'b000000 || s_hcnt !== 11'd15 || s_vcnt !== 10'd7) begin
            failures++;
            $display("FAIL mid_reset: got flags=%b h=%0d v=%0d expected 000000 15 7",
                     {s_hs, s_vs, s_hen, s_ven, s_fs, s_ls}, s_hcnt, s_vcnt);
        end
        checks++;
        if ({d_hs, d_vs, d_hen, d_ven} !== 4'b0000 || d_hcnt !== 11'd1039) begin
            failures++;
            $display("FAIL mid_reset_dflt: got flags=%b h=%0d expected 0000 1039", {d_hs, d_vs, d_hen, d_ven}, d_hcnt);
        end
        rst = 1'b0;
        tick(1);
        checks++;
        if (s_hcnt !== 11'd0 || s_vcnt !== 10'd0 || s_fs !== 1'b1 || s_ls !== 1'b1 || s_fc !== 8'd0) begin
            failures++;
            $display("FAIL mid_release: got h=%0d v=%0d fs=%b ls=%b fc=%0d expected 0 0 1 1 0",
                     s_hcnt, s_vcnt, s_fs, s_ls, s_fc);
        end
    endtask

    task automatic test_frame_wrap();
        do_reset();
        tick(255 * 128);
        checks++;
        if (s_fc !== 8'd255 || s_fs !== 1'b1) begin
            failures++;
            $display("FAIL wrap_255: got fc=%0d fs=%b expected 255 1", s_fc, s_fs);
        end
        tick(127);
        checks++;
        if (s_fc !== 8'd255 || s_fs !== 1'b0 || s_hcnt !== 11'd15 || s_vcnt !== 10'd7) begin
            failures++;
            $display("FAIL wrap_hold: got fc=%0d fs=%b h=%0d v=%0d expected 255 0 15 7", s_fc, s_fs, s_hcnt, s_vcnt);
        end
        tick(1);
        checks++;
        if (s_fc !== 8'd0 || s_fs !== 1'b1) begin
            failures++;
            $display("FAIL wrap_zero: got fc=%0d fs=%b expected 0 1", s_fc, s_fs);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        test_reset();
        test_line_default();
        test_frames_small();
        test_reset_mid();
        test_frame_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_scan_timing.md
VGA_SCAN_TIMING -- requirements
Module: vga_scan_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 56, horizontal front porch in pclk cycles.
REQ-003 SHALL have parameter H_SYNC, default 120, horizontal sync width in pclk cycles.
REQ-004 SHALL have parameter H_BP, default 64, horizontal back porch in pclk cycles.
REQ-005 SHALL have parameter V_ACTIVE, default 600, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 37, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 6, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 23, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 1, active level of hs and vs.
REQ-010 SHALL have port pclk, input, 1 bit, pixel clock; the only clock.
REQ-011 SHALL have port rst, input, 1 bit, reset: synchronous, active-high.
REQ-012 SHALL have port hen, output, 1 bit, horizontal visible-region enable.
REQ-013 SHALL have port ven, output, 1 bit, vertical visible-region enable.
REQ-014 SHALL have port hs, output, 1 bit, horizontal sync at SYNC_POL.
REQ-015 SHALL have port vs, output, 1 bit, vertical sync at SYNC_POL.
REQ-016 SHALL have port hcnt, output, 11 bits, current horizontal position.
REQ-017 SHALL have port vcnt, output, 10 bits, current vertical position.
REQ-018 SHALL have port frame_start, output, 1 bit, one-cycle pulse at position (0,0).
REQ-019 SHALL have port line_start, output, 1 bit, one-cycle pulse at every hcnt==0.
REQ-020 SHALL have port frame_cnt, output, 8 bits, free-running frame counter.

Function
REQ-021 SHALL advance hcnt by 1 per pclk, 0..H_TOTAL-1 (H_TOTAL = sum of the four H params = 1040), wrapping to 0.
REQ-022 SHALL advance vcnt by 1 only on the cycle hcnt wraps, 0..V_TOTAL-1 (=666), wrapping to 0; frame = 692640 cycles.
REQ-023 SHALL register every output; each output reflects the hcnt/vcnt value present in the same cycle (decode from next-state, zero added latency).
REQ-024 SHALL drive hen=1 iff hcnt<H_ACTIVE and ven=1 iff vcnt<V_ACTIVE, so the downstream pixel stage sees exactly 800x600 cycles with hen&&ven per frame.
REQ-025 SHALL drive hs=SYNC_POL iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (856..975 default); otherwise ~SYNC_POL.
REQ-026 SHALL drive vs=SYNC_POL iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC (637..642 default), for whole lines, transitions coinciding with hcnt==0.
REQ-027 SHALL pulse frame_start for exactly the cycle hcnt==0 and vcnt==0; line_start for every cycle hcnt==0, including line 0.
REQ-028 SHALL increment frame_cnt (mod 256) in the same cycle frame_start asserts; 255 wraps to 0.
REQ-029 SHALL never produce hcnt>=H_TOTAL or vcnt>=V_TOTAL, even across reset assertion on any cycle.

Reset
REQ-030 SHALL, while rst=1 at a pclk edge, load hcnt=H_TOTAL-1, vcnt=V_TOTAL-1, frame_cnt=0xFF, and force hen=0, ven=0, hs=vs=~SYNC_POL, frame_start=0, line_start=0.
REQ-031 SHALL, on the first pclk edge with rst=0, present hcnt=0, vcnt=0, hen=ven=1, frame_start=1, line_start=1, frame_cnt=0.
REQ-032 SHALL restart from REQ-030 state immediately when rst asserts mid-frame, with no partial sync pulse after the reset edge.

Configuration
REQ-033 SHALL honour macro VGA_SCAN_SYNC_DELAY_EN: when defined, hs and vs are delayed one extra pclk (one register stage) relative to hen/ven/hcnt/vcnt to match the pixel stage's registered colour output; reset value of the delay stage is ~SYNC_POL.
REQ-034 SHALL, without VGA_SCAN_SYNC_DELAY_EN, keep hs and vs cycle-aligned with hcnt/vcnt per REQ-025/026.

Verification
REQ-035 Release rst after 5 cycles -> first cycle: hcnt=0, vcnt=0, hen=ven=1, frame_start=1, frame_cnt=0.
REQ-036 Run one line -> hen high for exactly 800 cycles, hs high cycles 856..975 (120 cycles), line_start period 1040.
REQ-037 Run 2 frames -> frame_start period 692640 cycles, vs high for 6*1040=6240 cycles starting at vcnt=637, hcnt=0; hen&&ven count 480000 per frame.
REQ-038 Assert rst at hcnt=900, vcnt=640 (inside hs and vs) -> next edge hs=vs=0, hen=ven=0; release -> (0,0) with frame_start=1.
REQ-039 Force 256 frames (or preload) -> frame_cnt 255 wraps to 0 on frame_start.
REQ-040 Compile with VGA_SCAN_SYNC_DELAY_EN -> hs rises at hcnt=857, falls at hcnt=977; hen timing unchanged.
